scan_doubler_pipe: RTL
======================

Name: scan_doubler_pipe

Overview:
- Parametrised single-clock scan doubler. Takes source pixels (e.g. NES PPU at native rate, gated by a clock enable) and replays each source line twice on a generated VGA-style raster, with configurable horizontal scale and timing.
- Sits between the palette LUT and the VGA pins.
- Ping-pong line buffers and clock enables replace the dual-clock line buffer and the crossdomain sync of the previous video path.
- Adds frame lock tracking, overflow detection and optional scanline darkening.

Parameters:
- PIX_W, 15: pixel width; must be a multiple of 3 (CH_W = PIX_W/3 per channel, R in LSBs).
- SRC_W, 256: active source pixels per line; line buffer depth per bank.
- H_SCALE, 2: output pixels per source pixel (1, 2 or 4).
- H_OFFSET, 64: first active output column.
- H_TOTAL, 800: output columns per line.
- H_ACTIVE, 640: visible columns.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- V_TOTAL, 525: output lines per frame.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- src_ce  in  1  source pixel strobe.
- src_de  in  1  source active-pixel flag, sampled on src_ce.
- src_sof  in  1  source start-of-frame pulse, one clk wide.
- src_pixel  in  PIX_W  source pixel.
- out_ce  in  1  output pixel strobe.
- VGA_HS  out  1  horizontal sync, active-low.
- VGA_VS  out  1  vertical sync, active-low.
- VGA_PIXEL  out  PIX_W  output pixel; 0 outside the active window.
- VGA_BLANK  out  1  high outside H_ACTIVE x V_ACTIVE.
- VGA_HCOUNTER  out  11  output column, aligned with the pixel.
- VGA_VCOUNTER  out  11  output line, aligned with the pixel.
- locked  out  1  output raster is frame-locked to the source.
- overflow  out  1  sticky; set when more than SRC_W pixels arrive in one line.

Behaviour:
Reset:
- Reset values: VGA_HS=1, VGA_VS=1, VGA_PIXEL=0, VGA_BLANK=1, counters=0, locked=0, overflow=0.
- Internal state: wr_bank=0, wr_x=0, h=0, v=0, FSM=WAIT_SOF.
- Reset mid-line discards buffered data. Buffer contents are not cleared; the output is black until locked.

Write side (advances on clk with src_ce):
- src_de=1: write src_pixel to bank wr_bank at address wr_x, then wr_x++.
- wr_x == SRC_W: further pixels are dropped and overflow is set.
- Falling edge of src_de (sampled on src_ce): toggle wr_bank, set wr_x=0.
- src_sof: set wr_x=0 and clear the write line count.

Output timing (advances only on out_ce):
- h wraps at H_TOTAL-1. v increments on h wrap and wraps at V_TOTAL-1.
- Horizontal sync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Vertical sync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Active window: H_OFFSET <= h < H_OFFSET+SRC_W*H_SCALE, and v < V_ACTIVE.
- Read address rd_x = (h-H_OFFSET) >> log2(H_SCALE).
- Read bank = !wr_bank, latched at h wrap into each even v. The same bank is replayed on the odd line.

Pipeline:
- Address registered, RAM read, output registered: 2 out_ce ticks of latency.
- HS, VS, BLANK and both counters are delayed by the same 2 ticks, so all outputs stay aligned.

FSM:
- WAIT_SOF: output black (pixel forced 0, syncs still generated), locked=0. On src_sof, arm. At the next h wrap force v=0 and go to RUN.
- RUN: locked=1. When src_sof arrives, check v. If v is within 2 lines of V_TOTAL-1 or 0 (wrapping), stay in RUN. Otherwise go to RESYNC.
- RESYNC: locked=0, pixel black. At the next h wrap force v=0 and go to RUN.

Simultaneous events and edge cases:
- src_sof and a src_de falling edge in the same clk: both take effect.
- out_ce and src_ce in the same clk: independent; a same-address read/write collision returns old data, which is acceptable because banks differ.
- out_ce held low freezes all outputs.

Optional Feature:
- Macro: SCAN_DOUBLER_SCANLINES_EN.
- Defined: adds input port scanlines (1 bit). When scanlines=1 and the output line v is odd, each CH_W channel of VGA_PIXEL is shifted right by 1 (50% intensity). Timing is unchanged.
- Undefined: the port is absent and pixels pass unmodified.

Test Plan:
1. Reset held 3 clk with out_ce=1 -> VGA_HS=1, VGA_VS=1, VGA_BLANK=1, VGA_PIXEL=0, locked=0, overflow=0.
2. Free-run out_ce=1, no source -> HS low for h 656..751, VS low for v 490..491, 800x525 ticks per frame, locked stays 0.
3. src_sof, then 256 pixels of value x (x=0..255), then 1 line idle -> locked=1. Output lines 2k and 2k+1 each show each pixel twice starting at column 64 (col 64,65 = 0; col 574,575 = 255), and 0 at column 576.
4. 260 pixels in one line -> overflow=1 and stays set; pixels 256..259 are never displayed.
5. Locked, then src_sof delivered at v=200 -> locked drops to 0 for at least one line, then v restarts at 0 and locked=1.
6. With SCAN_DOUBLER_SCANLINES_EN, scanlines=1, pixel 15'h7FFF -> even lines output 7FFF, odd lines output 3DEF.

Source files
------------

// File: rtl/scan_doubler_pipe.sv
// rtl/scan_doubler_pipe.sv - single-clock ping-pong line-buffer scan doubler with frame lock
// Optional scanline darkening on odd output lines: define SCAN_DOUBLER_SCANLINES_EN.
module scan_doubler_pipe #(
    parameter int PIX_W    = 15,
    parameter int SRC_W    = 256,
    parameter int H_SCALE  = 2,
    parameter int H_OFFSET = 64,
    parameter int H_TOTAL  = 800,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_ce,
    input  logic             src_de,
    input  logic             src_sof,
    input  logic [PIX_W-1:0] src_pixel,
    input  logic             out_ce,
`ifdef SCAN_DOUBLER_SCANLINES_EN
    input  logic             scanlines,
`endif
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic [PIX_W-1:0] VGA_PIXEL,
    output logic             VGA_BLANK,
    output logic [10:0]      VGA_HCOUNTER,
    output logic [10:0]      VGA_VCOUNTER,
    output logic             locked,
    output logic             overflow
);
    localparam int AW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int XW    = $clog2(SRC_W + 1);
    localparam int SHIFT = $clog2(H_SCALE);
    localparam logic [XW-1:0] WR_FULL  = XW'(SRC_W);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG     = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] ACT_BEG    = 11'(H_OFFSET);
    localparam logic [10:0] ACT_END    = 11'(H_OFFSET + SRC_W * H_SCALE);
    localparam logic [10:0] V_NEAR_END = 11'(V_TOTAL - 3);

    typedef enum logic [1:0] {WAIT_SOF, RUN, RESYNC} state_t;

    logic [PIX_W-1:0] line_mem [2][SRC_W];

    logic          wr_bank_q, de_prev_q, overflow_q;
    logic [XW-1:0] wr_x_q;

    always_ff @(posedge clk) begin
        if (src_ce && src_de && (wr_x_q != WR_FULL))
            line_mem[wr_bank_q][wr_x_q[AW-1:0]] <= src_pixel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q  <= 1'b0;
            wr_x_q     <= '0;
            de_prev_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (src_ce) begin
                de_prev_q <= src_de;
                if (src_de) begin
                    if (wr_x_q == WR_FULL) overflow_q <= 1'b1;
                    else                   wr_x_q     <= wr_x_q + 1'b1;
                end
                if (de_prev_q && !src_de) begin
                    wr_bank_q <= ~wr_bank_q;
                    wr_x_q    <= '0;
                end
            end
            if (src_sof) wr_x_q <= '0;
        end
    end

    state_t      state_q, state_d;
    logic        armed_q, armed_d, force_v;
    logic [10:0] h_q, v_q, v_next;
    logic        rd_bank_q, wrap, v_near_edge;

    assign wrap        = out_ce && (h_q == H_LAST);
    assign v_near_edge = (v_q >= V_NEAR_END) || (v_q <= 11'd2);

    always_comb begin
        state_d = state_q;
        armed_d = 1'b0;
        force_v = 1'b0;
        unique case (state_q)
            WAIT_SOF: begin
                armed_d = armed_q | src_sof;
                if (wrap && armed_q) begin
                    state_d = RUN;
                    armed_d = 1'b0;
                    force_v = 1'b1;
                end
            end
            RUN:    if (src_sof && !v_near_edge) state_d = RESYNC;
            RESYNC: if (wrap) begin
                state_d = RUN;
                force_v = 1'b1;
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    assign v_next = (force_v || v_q == V_LAST) ? 11'd0 : v_q + 11'd1;

    // The read bank is chosen only entering even lines so each source line is replayed twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_SOF;
            armed_q   <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            if (out_ce) begin
                h_q <= (h_q == H_LAST) ? 11'd0 : h_q + 11'd1;
                if (h_q == H_LAST) begin
                    v_q <= v_next;
                    if (!v_next[0]) rd_bank_q <= ~wr_bank_q;
                end
            end
        end
    end

    logic          hs0, vs0, blank0, show0;
    logic [AW-1:0] rd_x0;

    assign hs0    = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign vs0    = !((v_q >= VS_BEG) && (v_q < VS_END));
    assign blank0 = !((h_q < H_ACT) && (v_q < V_ACT));
    assign show0  = (state_q == RUN) && (h_q >= ACT_BEG) && (h_q < ACT_END) && (v_q < V_ACT);
    assign rd_x0  = AW'((h_q - ACT_BEG) >> SHIFT);

    logic          s1_hs_q, s1_vs_q, s1_blank_q, s1_show_q, s1_bank_q;
    logic [AW-1:0] s1_x_q;
    logic [10:0]   s1_h_q, s1_v_q;

    logic             out_hs_q, out_vs_q, out_blank_q;
    logic [PIX_W-1:0] out_pix_q, pix_d;
    logic [10:0]      out_h_q, out_v_q;

`ifdef SCAN_DOUBLER_SCANLINES_EN
    localparam int CH_W = PIX_W / 3;

    function automatic logic [PIX_W-1:0] dim_pixel(input logic [PIX_W-1:0] p);
        logic [PIX_W-1:0] r;
        r = p >> 1;
        for (int c = 0; c < 3; c++) r[c*CH_W + CH_W - 1] = 1'b0;
        return r;
    endfunction
`endif

    always_comb begin
        pix_d = s1_show_q ? line_mem[s1_bank_q][s1_x_q] : '0;
`ifdef SCAN_DOUBLER_SCANLINES_EN
        if (scanlines && s1_v_q[0]) pix_d = dim_pixel(pix_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            s1_blank_q  <= 1'b1;
            s1_show_q   <= 1'b0;
            s1_bank_q   <= 1'b0;
            s1_x_q      <= '0;
            s1_h_q      <= '0;
            s1_v_q      <= '0;
            out_hs_q    <= 1'b1;
            out_vs_q    <= 1'b1;
            out_blank_q <= 1'b1;
            out_pix_q   <= '0;
            out_h_q     <= '0;
            out_v_q     <= '0;
        end else if (out_ce) begin
            s1_hs_q     <= hs0;
            s1_vs_q     <= vs0;
            s1_blank_q  <= blank0;
            s1_show_q   <= show0;
            s1_bank_q   <= rd_bank_q;
            s1_x_q      <= rd_x0;
            s1_h_q      <= h_q;
            s1_v_q      <= v_q;
            out_hs_q    <= s1_hs_q;
            out_vs_q    <= s1_vs_q;
            out_blank_q <= s1_blank_q;
            out_pix_q   <= pix_d;
            out_h_q     <= s1_h_q;
            out_v_q     <= s1_v_q;
        end
    end

    assign VGA_HS       = out_hs_q;
    assign VGA_VS       = out_vs_q;
    assign VGA_BLANK    = out_blank_q;
    assign VGA_PIXEL    = out_pix_q;
    assign VGA_HCOUNTER = out_h_q;
    assign VGA_VCOUNTER = out_v_q;
    assign locked       = (state_q == RUN);
    assign overflow     = overflow_q;
endmodule
